// File: rtl/id_pipe_stage_pkg.sv
// Shared constants for the ID stage: opcode/funct values, aluop/alusel
// encodings and the operand-source tag used by the forwarding muxes.
package id_pipe_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_PREF    = 6'b110011;
  localparam logic [5:0] OP_LW      = 6'b100011;

  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_SYNC = 6'b001111;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;

  localparam logic [7:0] ALUOP_NOP = 8'h00;
  localparam logic [7:0] ALUOP_OR  = 8'h25;
  localparam logic [7:0] ALUOP_AND = 8'h24;
  localparam logic [7:0] ALUOP_XOR = 8'h26;
  localparam logic [7:0] ALUOP_NOR = 8'h27;
  localparam logic [7:0] ALUOP_SLL = 8'h7c;
  localparam logic [7:0] ALUOP_SRL = 8'h02;
  localparam logic [7:0] ALUOP_SRA = 8'h03;
  localparam logic [7:0] ALUOP_LW  = 8'he3;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_LOAD  = 3'b100;

  localparam logic [31:0] ZERO_WORD    = 32'h0;
  localparam logic [4:0]  NOP_REG_ADDR = 5'h0;

  typedef enum logic [1:0] {
    SRC_IMM = 2'd0,
    SRC_REG = 2'd1,
    SRC_MEM = 2'd2,
    SRC_EX  = 2'd3
  } opnd_src_t;

endpackage

// File: rtl/id_pipe_stage_if.sv
// Signal bundle between IF/ID, regfile, forwarding network, pipeline
// controller and EX. slave = the ID stage, master = its environment.
interface id_pipe_stage_if #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int PERF_W   = 32
);
  logic [31:0]         inst_i;
  logic [31:0]         pc_i;
  logic [DATA_W-1:0]   reg1_data_i;
  logic [DATA_W-1:0]   reg2_data_i;
  logic                reg1_read_o;
  logic                reg2_read_o;
  logic [REG_AW-1:0]   reg1_addr_o;
  logic [REG_AW-1:0]   reg2_addr_o;
  logic                ex_wreg_i;
  logic [REG_AW-1:0]   ex_wd_i;
  logic [DATA_W-1:0]   ex_wdata_i;
  logic                ex_is_load_i;
  logic                mem_wreg_i;
  logic [REG_AW-1:0]   mem_wd_i;
  logic [DATA_W-1:0]   mem_wdata_i;
  logic                id_stall_i;
  logic                ex_stall_i;
  logic                flush_i;
  logic                stallreq_o;
  logic [ALUOP_W-1:0]  ex_aluop_o;
  logic [ALUSEL_W-1:0] ex_alusel_o;
  logic [DATA_W-1:0]   ex_reg1_o;
  logic [DATA_W-1:0]   ex_reg2_o;
  logic [REG_AW-1:0]   ex_wd_o;
  logic                ex_wreg_o;
  logic                ex_is_load_o;
  logic [31:0]         ex_pc_o;
  logic                ex_valid_o;
  logic                inst_invalid_o;
`ifdef ID_PERF_CNT_EN
  logic [PERF_W-1:0]   stall_cnt_o;
`endif

  modport slave (
    input  inst_i, pc_i, reg1_data_i, reg2_data_i,
           ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
           mem_wreg_i, mem_wd_i, mem_wdata_i,
           id_stall_i, ex_stall_i, flush_i,
    output reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stallreq_o,
           ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
           ex_is_load_o, ex_pc_o, ex_valid_o, inst_invalid_o
`ifdef ID_PERF_CNT_EN
    , output stall_cnt_o
`endif
  );

  modport master (
    output inst_i, pc_i, reg1_data_i, reg2_data_i,
           ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
           mem_wreg_i, mem_wd_i, mem_wdata_i,
           id_stall_i, ex_stall_i, flush_i,
    input  reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stallreq_o,
           ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
           ex_is_load_o, ex_pc_o, ex_valid_o, inst_invalid_o
`ifdef ID_PERF_CNT_EN
    , input stall_cnt_o
`endif
  );
endinterface

// File: rtl/id_pipe_stage_fwd_mux.sv
// Per-operand source select: EX forward, then MEM forward, then regfile,
// then immediate. Register $0 is never forwarded.
module id_fwd_mux
  import id_pipe_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              read,
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] imm,
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] operand
);
  opnd_src_t src;

  always_comb begin
    src = SRC_IMM;
    if (read && ex_wreg && (ex_wd == addr) && (addr != '0))
      src = SRC_EX;
    else if (read && mem_wreg && (mem_wd == addr) && (addr != '0))
      src = SRC_MEM;
    else if (read)
      src = SRC_REG;
  end

  always_comb begin
    case (src)
      SRC_EX:  operand = ex_wdata;
      SRC_MEM: operand = mem_wdata;
      SRC_REG: operand = rf_data;
      default: operand = imm;
    endcase
  end
endmodule

// File: rtl/id_pipe_stage.sv
// Decode stage with EX/MEM forwarding, load-use stall request and ID/EX register.
// Optional ID_PERF_CNT_EN adds a saturating stall-request cycle counter.
module id_pipe_stage
  import id_pipe_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int PERF_W   = 32
) (
  input logic            clk,
  input logic            rst,
  id_pipe_stage_if.slave bus
);
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;

  assign op    = bus.inst_i[31:26];
  assign rs    = bus.inst_i[25:21];
  assign rt    = bus.inst_i[20:16];
  assign rd    = bus.inst_i[15:11];
  assign sa    = bus.inst_i[10:6];
  assign funct = bus.inst_i[5:0];
  assign imm16 = bus.inst_i[15:0];

  logic [ALUOP_W-1:0]  aluop;
  logic [ALUSEL_W-1:0] alusel;
  logic                rd1, rd2, wreg, is_load, invalid, r3, shsa;
  logic [REG_AW-1:0]   wd;
  logic [DATA_W-1:0]   imm;

  always_comb begin
    aluop   = ALUOP_W'(ALUOP_NOP);
    alusel  = ALUSEL_W'(RES_NOP);
    rd1     = 1'b0;
    rd2     = 1'b0;
    wreg    = 1'b0;
    wd      = REG_AW'(NOP_REG_ADDR);
    imm     = '0;
    is_load = 1'b0;
    invalid = 1'b0;
    r3      = 1'b0;
    shsa    = 1'b0;
    case (op)
      OP_SPECIAL: begin
        invalid = 1'b1;
        if (sa == 5'd0) begin
          invalid = 1'b0;
          case (funct)
            F_OR:   begin aluop = ALUOP_W'(ALUOP_OR);  alusel = ALUSEL_W'(RES_LOGIC); r3 = 1'b1; end
            F_AND:  begin aluop = ALUOP_W'(ALUOP_AND); alusel = ALUSEL_W'(RES_LOGIC); r3 = 1'b1; end
            F_XOR:  begin aluop = ALUOP_W'(ALUOP_XOR); alusel = ALUSEL_W'(RES_LOGIC); r3 = 1'b1; end
            F_NOR:  begin aluop = ALUOP_W'(ALUOP_NOR); alusel = ALUSEL_W'(RES_LOGIC); r3 = 1'b1; end
            F_SLLV: begin aluop = ALUOP_W'(ALUOP_SLL); alusel = ALUSEL_W'(RES_SHIFT); r3 = 1'b1; end
            F_SRLV: begin aluop = ALUOP_W'(ALUOP_SRL); alusel = ALUSEL_W'(RES_SHIFT); r3 = 1'b1; end
            F_SRAV: begin aluop = ALUOP_W'(ALUOP_SRA); alusel = ALUSEL_W'(RES_SHIFT); r3 = 1'b1; end
            F_SYNC: ;
            default: invalid = 1'b1;
          endcase
        end
        // Shift-by-sa forms are only legal with rs=0; tried once the sa=0 group misses.
        if (invalid && (rs == 5'd0)) begin
          invalid = 1'b0;
          case (funct)
            F_SLL:  begin aluop = ALUOP_W'(ALUOP_SLL); alusel = ALUSEL_W'(RES_SHIFT); shsa = 1'b1; end
            F_SRL:  begin aluop = ALUOP_W'(ALUOP_SRL); alusel = ALUSEL_W'(RES_SHIFT); shsa = 1'b1; end
            F_SRA:  begin aluop = ALUOP_W'(ALUOP_SRA); alusel = ALUSEL_W'(RES_SHIFT); shsa = 1'b1; end
            default: invalid = 1'b1;
          endcase
        end
        if (r3) begin
          rd1 = 1'b1; rd2 = 1'b1; wreg = 1'b1; wd = REG_AW'(rd);
        end
        if (shsa) begin
          rd2 = 1'b1; wreg = 1'b1; wd = REG_AW'(rd); imm = DATA_W'(sa);
        end
      end
      OP_ORI: begin
        aluop = ALUOP_W'(ALUOP_OR); alusel = ALUSEL_W'(RES_LOGIC);
        rd1 = 1'b1; wreg = 1'b1; wd = REG_AW'(rt); imm = DATA_W'(imm16);
      end
      OP_ANDI: begin
        aluop = ALUOP_W'(ALUOP_AND); alusel = ALUSEL_W'(RES_LOGIC);
        rd1 = 1'b1; wreg = 1'b1; wd = REG_AW'(rt); imm = DATA_W'(imm16);
      end
      OP_XORI: begin
        aluop = ALUOP_W'(ALUOP_XOR); alusel = ALUSEL_W'(RES_LOGIC);
        rd1 = 1'b1; wreg = 1'b1; wd = REG_AW'(rt); imm = DATA_W'(imm16);
      end
      OP_LUI: begin
        aluop = ALUOP_W'(ALUOP_OR); alusel = ALUSEL_W'(RES_LOGIC);
        wreg = 1'b1; wd = REG_AW'(rt); imm = DATA_W'({imm16, 16'h0});
      end
      OP_PREF: ;
      OP_LW: begin
        aluop = ALUOP_W'(ALUOP_LW); alusel = ALUSEL_W'(RES_LOAD);
        rd1 = 1'b1; wreg = 1'b1; wd = REG_AW'(rt); is_load = 1'b1;
        imm = DATA_W'($signed(imm16));
      end
      default: invalid = 1'b1;
    endcase
  end

  logic              rd1_g, rd2_g;
  logic [REG_AW-1:0] addr1_g, addr2_g;
  logic [DATA_W-1:0] opnd1, opnd2;
  logic              stallreq;

  assign rd1_g   = rd1 & ~rst;
  assign rd2_g   = rd2 & ~rst;
  assign addr1_g = rst ? '0 : REG_AW'(rs);
  assign addr2_g = rst ? '0 : REG_AW'(rt);

  assign bus.reg1_read_o    = rd1_g;
  assign bus.reg2_read_o    = rd2_g;
  assign bus.reg1_addr_o    = addr1_g;
  assign bus.reg2_addr_o    = addr2_g;
  assign bus.inst_invalid_o = invalid & ~rst;

  assign stallreq = bus.ex_is_load_i && bus.ex_wreg_i && (bus.ex_wd_i != '0) &&
                    ((rd1_g && (bus.ex_wd_i == addr1_g)) ||
                     (rd2_g && (bus.ex_wd_i == addr2_g)));
  assign bus.stallreq_o = stallreq;

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
    .read(rd1_g), .addr(addr1_g), .rf_data(bus.reg1_data_i), .imm(imm),
    .ex_wreg(bus.ex_wreg_i), .ex_wd(bus.ex_wd_i), .ex_wdata(bus.ex_wdata_i),
    .mem_wreg(bus.mem_wreg_i), .mem_wd(bus.mem_wd_i), .mem_wdata(bus.mem_wdata_i),
    .operand(opnd1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd2 (
    .read(rd2_g), .addr(addr2_g), .rf_data(bus.reg2_data_i), .imm(imm),
    .ex_wreg(bus.ex_wreg_i), .ex_wd(bus.ex_wd_i), .ex_wdata(bus.ex_wdata_i),
    .mem_wreg(bus.mem_wreg_i), .mem_wd(bus.mem_wd_i), .mem_wdata(bus.mem_wdata_i),
    .operand(opnd2)
  );

  logic [ALUOP_W-1:0]  q_aluop;
  logic [ALUSEL_W-1:0] q_alusel;
  logic [DATA_W-1:0]   q_reg1, q_reg2;
  logic [REG_AW-1:0]   q_wd;
  logic                q_wreg, q_is_load, q_valid;
  logic [31:0]         q_pc;

  // Flush outranks an EX hold; a bubble is only inserted when EX is moving.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i || (bus.id_stall_i && !bus.ex_stall_i)) begin
      q_aluop   <= '0;
      q_alusel  <= '0;
      q_reg1    <= '0;
      q_reg2    <= '0;
      q_wd      <= '0;
      q_wreg    <= 1'b0;
      q_is_load <= 1'b0;
      q_pc      <= '0;
      q_valid   <= 1'b0;
    end else if (!bus.ex_stall_i) begin
      q_aluop   <= aluop;
      q_alusel  <= alusel;
      q_reg1    <= opnd1;
      q_reg2    <= opnd2;
      q_wd      <= wd;
      q_wreg    <= wreg;
      q_is_load <= is_load;
      q_pc      <= bus.pc_i;
      q_valid   <= 1'b1;
    end
  end

  assign bus.ex_aluop_o   = q_aluop;
  assign bus.ex_alusel_o  = q_alusel;
  assign bus.ex_reg1_o    = q_reg1;
  assign bus.ex_reg2_o    = q_reg2;
  assign bus.ex_wd_o      = q_wd;
  assign bus.ex_wreg_o    = q_wreg;
  assign bus.ex_is_load_o = q_is_load;
  assign bus.ex_pc_o      = q_pc;
  assign bus.ex_valid_o   = q_valid;

`ifdef ID_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stallreq && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign bus.stall_cnt_o = stall_cnt;
`endif
endmodule

// File: tb/tb_id_pipe_stage.sv
// Scoreboard bench for id_pipe_stage: directed scenarios then random traffic
// against an instruction-level reference model.
module tb_id_pipe_stage;
  import id_pipe_stage_pkg::*;

  localparam int DW = 32, AW = 5, OW = 8, SW = 3, PW = 4;
  localparam int EXP_W = OW + SW + DW + DW + AW + 1 + 1 + 32 + 1;

  typedef enum {M_OR, M_AND, M_XOR, M_NOR, M_SLLV, M_SRLV, M_SRAV, M_SYNC,
                M_SLL, M_SRL, M_SRA, M_ORI, M_ANDI, M_XORI, M_LUI, M_PREF,
                M_LW, M_BAD} mn_t;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        r1, r2, wreg;
    logic [4:0]  wd;
    logic [31:0] imm;
    logic        ld, bad;
  } dec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_pipe_stage_if #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW), .ALUSEL_W(SW), .PERF_W(PW)) bus ();
  id_pipe_stage #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW), .ALUSEL_W(SW), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [31:0] rf [32];
  assign bus.reg1_data_i = rf[bus.reg1_addr_o];
  assign bus.reg2_data_i = rf[bus.reg2_addr_o];

  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q [$];
  logic [EXP_W-1:0] ex_m;
  logic [EXP_W-1:0] mon_e;
`ifdef ID_PERF_CNT_EN
  logic [PW-1:0] cnt_q [$];
  logic [PW-1:0] cnt_m = '0;
  logic [PW-1:0] mon_c;
`endif

  logic [5:0] rfun [7]  = '{6'b100101, 6'b100100, 6'b100110, 6'b100111, 6'b000100, 6'b000110, 6'b000111};
  logic [5:0] sfun [3]  = '{6'b000000, 6'b000010, 6'b000011};
  logic [5:0] iop  [6]  = '{6'b001101, 6'b001100, 6'b001110, 6'b001111, 6'b110011, 6'b100011};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic mn_t classify(input logic [31:0] i);
    if (i[31:26] == 6'd0) begin
      if (i[10:6] == 5'd0) begin
        case (i[5:0])
          6'b100101: return M_OR;
          6'b100100: return M_AND;
          6'b100110: return M_XOR;
          6'b100111: return M_NOR;
          6'b000100: return M_SLLV;
          6'b000110: return M_SRLV;
          6'b000111: return M_SRAV;
          6'b001111: return M_SYNC;
          default: ;
        endcase
      end
      if (i[25:21] == 5'd0) begin
        case (i[5:0])
          6'b000000: return M_SLL;
          6'b000010: return M_SRL;
          6'b000011: return M_SRA;
          default: ;
        endcase
      end
      return M_BAD;
    end
    case (i[31:26])
      6'b001101: return M_ORI;
      6'b001100: return M_ANDI;
      6'b001110: return M_XORI;
      6'b001111: return M_LUI;
      6'b110011: return M_PREF;
      6'b100011: return M_LW;
      default:   return M_BAD;
    endcase
  endfunction

  function automatic dec_t decode(input logic [31:0] i);
    mn_t  mn = classify(i);
    dec_t d  = '0;
    case (mn)
      M_OR, M_ORI, M_LUI: d.aluop = ALUOP_OR;
      M_AND, M_ANDI:      d.aluop = ALUOP_AND;
      M_XOR, M_XORI:      d.aluop = ALUOP_XOR;
      M_NOR:              d.aluop = ALUOP_NOR;
      M_SLLV, M_SLL:      d.aluop = ALUOP_SLL;
      M_SRLV, M_SRL:      d.aluop = ALUOP_SRL;
      M_SRAV, M_SRA:      d.aluop = ALUOP_SRA;
      M_LW:               d.aluop = ALUOP_LW;
      default:            d.aluop = ALUOP_NOP;
    endcase
    if (mn inside {M_OR, M_AND, M_XOR, M_NOR, M_ORI, M_ANDI, M_XORI, M_LUI}) d.alusel = RES_LOGIC;
    if (mn inside {M_SLLV, M_SRLV, M_SRAV, M_SLL, M_SRL, M_SRA})             d.alusel = RES_SHIFT;
    if (mn == M_LW)                                                          d.alusel = RES_LOAD;
    if (mn inside {M_OR, M_AND, M_XOR, M_NOR, M_SLLV, M_SRLV, M_SRAV}) begin
      d.r1 = 1; d.r2 = 1; d.wreg = 1; d.wd = i[15:11];
    end
    if (mn inside {M_SLL, M_SRL, M_SRA}) begin
      d.r2 = 1; d.wreg = 1; d.wd = i[15:11]; d.imm = {27'd0, i[10:6]};
    end
    if (mn inside {M_ORI, M_ANDI, M_XORI}) begin
      d.r1 = 1; d.wreg = 1; d.wd = i[20:16]; d.imm = {16'h0, i[15:0]};
    end
    if (mn == M_LUI) begin
      d.wreg = 1; d.wd = i[20:16]; d.imm = {i[15:0], 16'h0};
    end
    if (mn == M_LW) begin
      d.r1 = 1; d.wreg = 1; d.wd = i[20:16]; d.ld = 1; d.imm = {{16{i[15]}}, i[15:0]};
    end
    d.bad = (mn == M_BAD);
    return d;
  endfunction

  function automatic logic [31:0] pick(input logic rd, input logic [4:0] a, input logic [31:0] imm);
    if (rd && bus.ex_wreg_i && bus.ex_wd_i == a && a != 0)   return bus.ex_wdata_i;
    if (rd && bus.mem_wreg_i && bus.mem_wd_i == a && a != 0) return bus.mem_wdata_i;
    if (rd) return rf[a];
    return imm;
  endfunction

  function automatic logic [31:0] gen_inst();
    int k = $urandom_range(0, 17);
    logic [4:0] rs = 5'($urandom_range(0, 7));
    logic [4:0] rt = 5'($urandom_range(0, 7));
    logic [4:0] rd = 5'($urandom_range(0, 7));
    logic [15:0] im = 16'($urandom);
    if (k < 7)  return {6'd0, rs, rt, rd, 5'd0, rfun[k]};
    if (k == 7) return {6'd0, rs, rt, rd, 5'd0, 6'b001111};
    if (k < 11) return {6'd0, 5'd0, rt, rd, 5'($urandom), sfun[k-8]};
    if (k < 17) return {iop[k-11], rs, rt, im};
    return $urandom;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_ctl(input logic r, input logic fl, input logic ids, input logic exs);
    rst = r; bus.flush_i = fl; bus.id_stall_i = ids; bus.ex_stall_i = exs;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] ewd, input logic [31:0] ewdata, input logic el,
                         input logic mw, input logic [4:0] mwd, input logic [31:0] mwdata);
    bus.ex_wreg_i = ew; bus.ex_wd_i = ewd; bus.ex_wdata_i = ewdata; bus.ex_is_load_i = el;
    bus.mem_wreg_i = mw; bus.mem_wd_i = mwd; bus.mem_wdata_i = mwdata;
  endtask

  task automatic drv(input logic [31:0] inst, input logic [31:0] pc);
    bus.inst_i = inst; bus.pc_i = pc;
  endtask

  // Checks combinational outputs, predicts the next ID/EX contents, advances one cycle.
  task automatic cycle();
    dec_t d;
    logic [4:0] rs, rt;
    logic stall_exp;
    #1;
    d  = decode(bus.inst_i);
    rs = bus.inst_i[25:21];
    rt = bus.inst_i[20:16];
    stall_exp = !rst && bus.ex_is_load_i && bus.ex_wreg_i && bus.ex_wd_i != 0 &&
                ((d.r1 && bus.ex_wd_i == rs) || (d.r2 && bus.ex_wd_i == rt));
    check("comb_outputs",
          {bus.reg1_read_o, bus.reg2_read_o, bus.reg1_addr_o, bus.reg2_addr_o, bus.stallreq_o, bus.inst_invalid_o},
          rst ? 128'd0 : {d.r1, d.r2, rs, rt, stall_exp, d.bad});
    if (rst || bus.flush_i || (bus.id_stall_i && !bus.ex_stall_i))
      ex_m = '0;
    else if (!bus.ex_stall_i)
      ex_m = {d.aluop, d.alusel, pick(d.r1, rs, d.imm), pick(d.r2, rt, d.imm),
              d.wd, d.wreg, d.ld, bus.pc_i, 1'b1};
    exp_q.push_back(ex_m);
`ifdef ID_PERF_CNT_EN
    if (rst) cnt_m = '0;
    else if (stall_exp && cnt_m != '1) cnt_m = cnt_m + 1'b1;
    cnt_q.push_back(cnt_m);
`endif
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("ex_regs",
            {bus.ex_aluop_o, bus.ex_alusel_o, bus.ex_reg1_o, bus.ex_reg2_o, bus.ex_wd_o,
             bus.ex_wreg_o, bus.ex_is_load_o, bus.ex_pc_o, bus.ex_valid_o}, mon_e);
    end
`ifdef ID_PERF_CNT_EN
    if (cnt_q.size() != 0) begin
      mon_c = cnt_q.pop_front();
      check("stall_cnt", bus.stall_cnt_o, mon_c);
    end
`endif
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'h0;
    ex_m = '0;
    drv(32'h0, 32'h0);
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    set_ctl(1, 0, 0, 0);
    cycle();
    cycle();
    check("rst_valid", bus.ex_valid_o, 0);
    set_ctl(0, 0, 0, 0);

    drv({6'b001101, 5'd0, 5'd1, 16'h1100}, 32'h100);
    cycle();
    check("ori", {bus.ex_aluop_o, bus.ex_reg1_o, bus.ex_reg2_o, bus.ex_wd_o, bus.ex_wreg_o, bus.ex_valid_o},
          {ALUOP_OR, 32'h0, 32'h00001100, 5'd1, 1'b1, 1'b1});

    drv({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100101}, 32'h104);
    set_fwd(1, 1, 32'hAAAA0000, 0, 1, 2, 32'h0000FFFF);
    cycle();
    check("fwd_ex_mem", {bus.ex_reg1_o, bus.ex_reg2_o}, {32'hAAAA0000, 32'h0000FFFF});

    set_fwd(1, 1, 32'h11, 0, 1, 1, 32'h22);
    cycle();
    check("fwd_ex_wins", bus.ex_reg1_o, 32'h11);

    drv({6'd0, 5'd0, 5'd0, 5'd3, 5'd0, 6'b100101}, 32'h108);
    set_fwd(1, 0, 32'h11, 0, 1, 0, 32'h22);
    cycle();
    check("no_fwd_r0", {bus.ex_reg1_o, bus.ex_reg2_o}, 64'h0);

    drv({6'd0, 5'd4, 5'd6, 5'd5, 5'd0, 6'b100100}, 32'h10c);
    set_fwd(1, 4, $urandom, 1, 0, 0, 0);
    set_ctl(0, 0, 1, 0);
    #1 check("ld_use_stallreq", bus.stallreq_o, 1);
    cycle();
    check("ld_use_bubble", bus.ex_valid_o, 0);
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    set_ctl(0, 0, 0, 0);
    cycle();
    check("and_after_bubble", {bus.ex_aluop_o, bus.ex_valid_o}, {ALUOP_AND, 1'b1});

    drv({6'b001101, 5'd2, 5'd7, 16'h1234}, 32'h110);
    set_ctl(0, 0, 0, 1);
    repeat (3) cycle();
    check("ex_hold", {bus.ex_aluop_o, bus.ex_wd_o, bus.ex_valid_o}, {ALUOP_AND, 5'd5, 1'b1});
    set_ctl(0, 1, 0, 1);
    cycle();
    check("flush_in_stall", bus.ex_valid_o, 0);
    set_ctl(0, 0, 0, 0);
    cycle();
    set_ctl(0, 0, 0, 1);
    cycle();
    set_ctl(1, 0, 0, 1);
    cycle();
    check("rst_mid_hold", {bus.ex_aluop_o, bus.ex_reg2_o, bus.ex_wd_o, bus.ex_wreg_o, bus.ex_pc_o, bus.ex_valid_o}, 0);
    set_ctl(0, 0, 0, 0);

    drv({6'b111111, 26'($urandom)}, 32'h120);
    #1 check("invalid_flag", bus.inst_invalid_o, 1);
    cycle();
    check("invalid_nop", {bus.ex_wreg_o, bus.ex_valid_o}, 2'b01);

`ifdef ID_PERF_CNT_EN
    set_ctl(1, 0, 0, 0);
    cycle();
    set_ctl(0, 0, 1, 0);
    drv({6'd0, 5'd4, 5'd6, 5'd5, 5'd0, 6'b100100}, 32'h130);
    set_fwd(1, 4, 0, 1, 0, 0, 0);
    repeat (5) cycle();
    check("cnt_five", bus.stall_cnt_o, 5);
    repeat (15) cycle();
    check("cnt_saturate", bus.stall_cnt_o, {PW{1'b1}});
    set_ctl(0, 0, 0, 0);
`endif

    for (int n = 0; n < 400; n++) begin
      drv(gen_inst(), $urandom);
      set_fwd($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
      set_ctl($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      cycle();
    end

    set_ctl(0, 0, 0, 0);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
